// File: rtl/control_pipe.sv
// control_pipe: ID decode feeding registered EX/MEM/WB control words,
// with a mul/div occupancy FSM that holds EX for multi-cycle ops.
module control_pipe #(
  parameter int ENABLE_M   = 1,
  parameter int MUL_CYCLES = 1,
  parameter int DIV_CYCLES = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       stall_in,
  input  logic       flush_ex,
  output logic       id_stall,
  output logic [8:0] ex_ctrl,
  output logic [8:0] mem_ctrl,
  output logic [8:0] wb_ctrl,
  output logic       ex_reg_wr_en,
  output logic       mem_reg_wr_en,
  output logic       wb_reg_wr_en,
  output logic       md_busy
);

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_R3  = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JLR = 7'b1100111;

  localparam int IL  = 8;
  localparam int MD  = 7;
  localparam int RD  = 4;
  localparam int WR  = 3;
  localparam int JB  = 2;
  localparam int IMM = 1;
  localparam int PC  = 0;

  localparam logic [6:0] MUL_N = 7'(MUL_CYCLES);
  localparam logic [6:0] DIV_N = 7'(DIV_CYCLES);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t     state;
  logic [5:0] cnt;
  logic [8:0] dec;
  logic       dec_wr;
  logic [6:0] dec_n;
  logic       f7_base;
  logic       f7_alt;
  logic       f7_m;
  logic       alt_ok;

  assign f7_base = (funct7 == 7'b0000000);
  assign f7_alt  = (funct7 == 7'b0100000);
  assign f7_m    = (funct7 == 7'b0000001);
  assign alt_ok  = (funct3 == 3'b000) || (funct3 == 3'b101);

  assign md_busy  = (state == BUSY);
  assign id_stall = rst_n & (md_busy | stall_in);

  // ID decode of the instruction fields into a control word
  always_comb begin
    dec    = '0;
    dec_wr = 1'b0;
    dec_n  = 7'd1;
    if (id_valid) begin
      unique case (1'b1)
        opcode == OP_IMM: begin
          dec_wr   = 1'b1;
          dec[IMM] = 1'b1;
        end
        opcode == OP_R3: begin
          if (f7_m && ENABLE_M != 0) begin
            dec_wr   = 1'b1;
            dec[MD]  = 1'b1;
            dec[6:5] = 2'd3;
            dec_n    = funct3[2] ? DIV_N : MUL_N;
          end else if (f7_base || (f7_alt && alt_ok)) begin
            dec_wr = 1'b1;
          end else begin
            dec[IL] = 1'b1;
          end
        end
        opcode == OP_LD: begin
          dec_wr   = 1'b1;
          dec[IMM] = 1'b1;
          dec[RD]  = 1'b1;
          dec[6:5] = 2'd2;
        end
        opcode == OP_ST: begin
          dec[IMM] = 1'b1;
          dec[WR]  = 1'b1;
        end
        opcode == OP_BR: begin
          dec[PC]  = 1'b1;
          dec[IMM] = 1'b1;
          dec[JB]  = 1'b1;
        end
        opcode == OP_LUI: begin
          dec_wr   = 1'b1;
          dec[IMM] = 1'b1;
        end
        opcode == OP_AUI: begin
          dec_wr   = 1'b1;
          dec[PC]  = 1'b1;
          dec[IMM] = 1'b1;
        end
        opcode == OP_JAL: begin
          dec_wr   = 1'b1;
          dec[PC]  = 1'b1;
          dec[IMM] = 1'b1;
          dec[JB]  = 1'b1;
          dec[6:5] = 2'd1;
        end
        opcode == OP_JLR: begin
          dec_wr   = 1'b1;
          dec[IMM] = 1'b1;
          dec[JB]  = 1'b1;
          dec[6:5] = 2'd1;
        end
        default: dec[IL] = 1'b1;
      endcase
    end
  end

  // EX register and mul/div occupancy FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      ex_ctrl      <= '0;
      ex_reg_wr_en <= 1'b0;
    end else if (flush_ex) begin
      state        <= IDLE;
      cnt          <= '0;
      ex_ctrl      <= '0;
      ex_reg_wr_en <= 1'b0;
    end else if (!stall_in) begin
      if (state == BUSY) begin
        if (cnt == 6'd0) state <= IDLE;
        else cnt <= cnt - 6'd1;
      end else begin
        ex_ctrl      <= dec;
        ex_reg_wr_en <= dec_wr;
        if (dec[MD] && dec_n > 7'd1) begin
          state <= BUSY;
          cnt   <= 6'(dec_n - 7'd2);
        end
      end
    end
  end

  // MEM/WB registers; MEM takes bubbles while EX is occupied
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ctrl      <= '0;
      mem_reg_wr_en <= 1'b0;
      wb_ctrl       <= '0;
      wb_reg_wr_en  <= 1'b0;
    end else if (!stall_in) begin
      if (state == BUSY) begin
        mem_ctrl      <= '0;
        mem_reg_wr_en <= 1'b0;
      end else begin
        mem_ctrl      <= ex_ctrl;
        mem_reg_wr_en <= ex_reg_wr_en;
      end
      wb_ctrl      <= mem_ctrl;
      wb_reg_wr_en <= mem_reg_wr_en;
    end
  end

endmodule

// File: tb/tb_control_pipe.sv
// tb_control_pipe: directed scoreboard bench for control_pipe,
// with a second instance built without the M extension.
module tb_control_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       stall_in;
  logic       flush_ex;

  logic       id_stall, md_busy;
  logic [8:0] ex_ctrl, mem_ctrl, wb_ctrl;
  logic       ex_wr, mem_wr, wb_wr;

  logic       id_stall_b, md_busy_b;
  logic [8:0] ex_ctrl_b, mem_ctrl_b, wb_ctrl_b;
  logic       ex_wr_b, mem_wr_b, wb_wr_b;

  control_pipe dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .stall_in(stall_in), .flush_ex(flush_ex),
    .id_stall(id_stall),
    .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
    .ex_reg_wr_en(ex_wr), .mem_reg_wr_en(mem_wr),
    .wb_reg_wr_en(wb_wr), .md_busy(md_busy)
  );

  control_pipe #(.ENABLE_M(0)) dut_nom (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .stall_in(stall_in), .flush_ex(flush_ex),
    .id_stall(id_stall_b),
    .ex_ctrl(ex_ctrl_b), .mem_ctrl(mem_ctrl_b), .wb_ctrl(wb_ctrl_b),
    .ex_reg_wr_en(ex_wr_b), .mem_reg_wr_en(mem_wr_b),
    .wb_reg_wr_en(wb_wr_b), .md_busy(md_busy_b)
  );

  always #5 clk = ~clk;

  // {reg_wr_en, ctrl} expected words
  localparam logic [9:0] W_BUB = 10'h000;
  localparam logic [9:0] W_ADD = 10'h200;
  localparam logic [9:0] W_IMM = 10'h202;
  localparam logic [9:0] W_AUI = 10'h203;
  localparam logic [9:0] W_JAL = 10'h227;
  localparam logic [9:0] W_JLR = 10'h226;
  localparam logic [9:0] W_BR  = 10'h007;
  localparam logic [9:0] W_ST  = 10'h00A;
  localparam logic [9:0] W_LD  = 10'h252;
  localparam logic [9:0] W_MD  = 10'h2E0;
  localparam logic [9:0] W_ILL = 10'h100;

  typedef struct packed {
    logic       v;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [9:0] e;
    logic [9:0] e2;
  } step_t;

  localparam logic [6:0] R3 = 7'b0110011;

  step_t tbl [0:15] = '{
    '{1'b1, 7'b0000011, 3'b010, 7'h00, W_LD,  W_LD},
    '{1'b1, 7'b0100011, 3'b010, 7'h00, W_ST,  W_ST},
    '{1'b0, 7'b0000011, 3'b010, 7'h00, W_BUB, W_BUB},
    '{1'b1, 7'b0010011, 3'b000, 7'h00, W_IMM, W_IMM},
    '{1'b1, 7'b0110111, 3'b000, 7'h00, W_IMM, W_IMM},
    '{1'b1, 7'b0010111, 3'b000, 7'h00, W_AUI, W_AUI},
    '{1'b1, 7'b1101111, 3'b000, 7'h00, W_JAL, W_JAL},
    '{1'b1, 7'b1100111, 3'b000, 7'h00, W_JLR, W_JLR},
    '{1'b1, 7'b1100011, 3'b001, 7'h00, W_BR,  W_BR},
    '{1'b1, R3,         3'b000, 7'h20, W_ADD, W_ADD},
    '{1'b1, R3,         3'b101, 7'h20, W_ADD, W_ADD},
    '{1'b1, R3,         3'b001, 7'h20, W_ILL, W_ILL},
    '{1'b1, R3,         3'b000, 7'h02, W_ILL, W_ILL},
    '{1'b1, 7'b1111111, 3'b000, 7'h00, W_ILL, W_ILL},
    '{1'b1, R3,         3'b000, 7'h01, W_MD,  W_ILL},
    '{1'b1, R3,         3'b000, 7'h00, W_ADD, W_ADD}
  };

  int n_chk  = 0;
  int n_fail = 0;
  logic [9:0] q[$];
  logic [9:0] last_wb;

  task automatic chk(input string tag, input logic [9:0] obs,
                     input logic [9:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [6:0] op,
                       input logic [2:0] f3, input logic [6:0] f7);
    id_valid = v;
    opcode   = op;
    funct3   = f3;
    funct7   = f7;
  endtask

  // issue one instruction through a free-flowing pipe and score it
  task automatic issue(input step_t s);
    drive(s.v, s.op, s.f3, s.f7);
    q.push_back(s.e);
    tick();
    chk("ex", {ex_wr, ex_ctrl}, q[2]);
    chk("mem", {mem_wr, mem_ctrl}, q[1]);
    chk("wb", {wb_wr, wb_ctrl}, q[0]);
    chk("ex_nom", {ex_wr_b, ex_ctrl_b}, s.e2);
    chk("no_stall", {9'd0, id_stall}, 10'd0);
    chk("idle", {9'd0, md_busy}, 10'd0);
    last_wb = q.pop_front();
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_ex"}, {ex_wr, ex_ctrl}, W_BUB);
    chk({tag, "_mem"}, {mem_wr, mem_ctrl}, W_BUB);
    chk({tag, "_wb"}, {wb_wr, wb_ctrl}, W_BUB);
    chk({tag, "_busy"}, {9'd0, md_busy}, 10'd0);
    chk({tag, "_stall"}, {9'd0, id_stall}, 10'd0);
  endtask

  initial begin
    int st_cnt;
    int bub;
    int arr;

    rst_n    = 1'b0;
    stall_in = 1'b1;
    flush_ex = 1'b0;
    drive(1'b1, 7'b0000011, 3'b010, 7'h00);
    #12;
    all_zero("rst");
    stall_in = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    q       = '{W_BUB, W_BUB};
    last_wb = W_BUB;

    for (int i = 0; i < 16; i++) issue(tbl[i]);

    // stall outside BUSY, then flush under stall
    stall_in = 1'b1;
    drive(1'b1, 7'b0000011, 3'b010, 7'h00);
    tick();
    chk("hold_ex", {ex_wr, ex_ctrl}, q[1]);
    chk("hold_mem", {mem_wr, mem_ctrl}, q[0]);
    chk("hold_wb", {wb_wr, wb_ctrl}, last_wb);
    chk("hold_stall", {9'd0, id_stall}, 10'd1);
    flush_ex = 1'b1;
    tick();
    chk("flush_ex", {ex_wr, ex_ctrl}, W_BUB);
    chk("flush_mem", {mem_wr, mem_ctrl}, q[0]);
    chk("flush_wb", {wb_wr, wb_ctrl}, last_wb);
    stall_in = 1'b0;
    flush_ex = 1'b0;
    q[1] = W_BUB;
    issue(tbl[3]);

    // DIV with 32-cycle occupancy
    drive(1'b1, R3, 3'b100, 7'h01);
    tick();
    chk("div_ex", {ex_wr, ex_ctrl}, W_MD);
    chk("div_busy", {9'd0, md_busy}, 10'd1);
    drive(1'b1, R3, 3'b000, 7'h00);
    st_cnt = 0;
    bub    = 0;
    arr    = 0;
    for (int e = 1; e <= 40; e++) begin
      if (e > 1) tick();
      if (id_stall) st_cnt++;
      if ({mem_wr, mem_ctrl} == W_BUB) bub++;
      if ({mem_wr, mem_ctrl} == W_MD) begin
        arr = e;
        break;
      end
    end
    chk("div_stalls", 10'(st_cnt), 10'd31);
    chk("div_bubbles", 10'(bub), 10'd31);
    chk("div_arrive", 10'(arr), 10'd33);
    chk("div_next_ex", {ex_wr, ex_ctrl}, W_ADD);
    tick();
    chk("div_wb", {wb_wr, wb_ctrl}, W_MD);
    chk("div_add_mem", {mem_wr, mem_ctrl}, W_ADD);

    // stall inside BUSY, then flush+stall at count 10
    drive(1'b1, R3, 3'b110, 7'h01);
    tick();
    drive(1'b1, R3, 3'b000, 7'h00);
    repeat (10) tick();
    stall_in = 1'b1;
    repeat (3) tick();
    chk("bstall_ex", {ex_wr, ex_ctrl}, W_MD);
    chk("bstall_busy", {9'd0, md_busy}, 10'd1);
    stall_in = 1'b0;
    repeat (10) tick();
    chk("pre_abort_busy", {9'd0, md_busy}, 10'd1);
    chk("pre_abort_mem", {mem_wr, mem_ctrl}, W_BUB);
    stall_in = 1'b1;
    flush_ex = 1'b1;
    tick();
    chk("abort_busy", {9'd0, md_busy}, 10'd0);
    chk("abort_ex", {ex_wr, ex_ctrl}, W_BUB);
    chk("abort_mem", {mem_wr, mem_ctrl}, W_BUB);
    chk("abort_stall", {9'd0, id_stall}, 10'd1);
    stall_in = 1'b0;
    flush_ex = 1'b0;
    tick();
    chk("post_abort_ex", {ex_wr, ex_ctrl}, W_ADD);
    chk("post_abort_stall", {9'd0, id_stall}, 10'd0);
    chk("post_abort_busy", {9'd0, md_busy}, 10'd0);

    // reset mid-DIV at count 5
    drive(1'b1, R3, 3'b101, 7'h01);
    tick();
    drive(1'b1, R3, 3'b000, 7'h00);
    repeat (25) tick();
    chk("prerst_busy", {9'd0, md_busy}, 10'd1);
    #3;
    rst_n = 1'b0;
    #1;
    all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_add_ex", {ex_wr, ex_ctrl}, W_ADD);
    chk("rst_add_stall", {9'd0, id_stall}, 10'd0);
    chk("rst_add_busy", {9'd0, md_busy}, 10'd0);
    tick();
    chk("rst_add_mem", {mem_wr, mem_ctrl}, W_ADD);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/control_pipe.md
CONTROL_PIPE -- requirements
Module: control_pipe

Interface
REQ-001 SHALL provide parameter ENABLE_M, default 1, meaning RV32M decode is enabled (0 means M encodings are illegal).
REQ-002 SHALL provide parameter MUL_CYCLES, default 1, meaning EX occupancy in cycles for MUL* instructions (legal range 1-64).
REQ-003 SHALL provide parameter DIV_CYCLES, default 32, meaning EX occupancy in cycles for DIV*/REM* instructions (legal range 1-64).
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 Port: clk  in  1  rising-edge clock.
REQ-006 Port: rst_n  in  1  asynchronous active-low reset.
REQ-007 Port: id_valid  in  1  ID stage holds a real instruction.
REQ-008 Port: opcode / funct3 / funct7  in  7/3/7  instruction fields, with opcodes as defined in inst_defs.sv.
REQ-009 Port: stall_in  in  1  external freeze of all pipeline registers.
REQ-010 Port: flush_ex  in  1  replace the incoming ID->EX word with a bubble.
REQ-011 Port: id_stall  out  1  ID/IF must hold their current instruction.
REQ-012 Port: ex_ctrl / mem_ctrl / wb_ctrl  out  9 each  registered control word per stage: {illegal, md_op, reg_write_ctrl[1:0], mem_rd_en, mem_wr_en, jump_branch_sel, imm_rs2_sel, pc_rs1_sel}, plus a separate 1-bit reg_wr_en per stage.
REQ-013 Port: md_busy  out  1  mul/div FSM is in the BUSY state.

Function
REQ-014 Decode (combinational, ID) SHALL produce: OP_IMM {wr, imm, rwc=0}; OP_R3 {wr, rwc=0}; LD {wr, imm, rd, rwc=2}; ST {imm, mem_wr}; BR {pc, imm, jb}; LUI {wr, imm, rwc=0}; AUIPC {pc, wr, imm, rwc=0}; JAL {pc, wr, imm, jb, rwc=1}; JALR {wr, imm, jb, rwc=1}.
REQ-015 OP_R3 with funct7=0000001 and ENABLE_M=1 SHALL decode as md_op=1, wr=1, rwc=3; funct3[2]=0 is MUL-class and funct3[2]=1 is DIV-class.
REQ-016 Illegal cases SHALL decode as an all-zero word with illegal=1: unknown opcode; OP_R3 with funct7 not in {0000000, 0100000, 0000001}; funct7=0100000 with funct3 not in {000, 101}; funct7=0000001 with ENABLE_M=0.
REQ-017 id_valid=0 SHALL decode as a bubble: the all-zero word with illegal=0.
REQ-018 Latency: the decoded word SHALL appear on ex_ctrl 1 cycle after sampling, on mem_ctrl after 2 cycles, and on wb_ctrl after 3 cycles, absent stalls.
REQ-019 FSM states SHALL be IDLE and BUSY; the counter width SHALL be 6 bits.
REQ-020 IDLE->BUSY SHALL occur when an md_op word is loaded into EX and its cycle count N>1; the counter then loads N-2.
REQ-021 In BUSY: EX holds its word; mem_ctrl loads a bubble each cycle; id_stall=1; the counter decrements each non-stalled cycle.
REQ-022 BUSY->IDLE SHALL occur on the cycle the counter is 0; on the next edge the md word advances to MEM, so the total EX occupancy is exactly N cycles.
REQ-023 N=1 SHALL never enter BUSY and SHALL insert no stall.
REQ-024 id_stall SHALL equal md_busy OR stall_in.
REQ-025 stall_in=1 SHALL hold all stage registers and the counter unchanged, including in BUSY.
REQ-026 flush_ex=1 SHALL load a bubble into EX even when stall_in=1; MEM/WB still obey stall_in.
REQ-027 flush_ex=1 in BUSY SHALL abort to IDLE, put a bubble in EX, and clear the counter.
REQ-028 reg_wr_en SHALL never be 1 in any stage word with illegal=1.

Reset
REQ-029 rst_n=0 SHALL asynchronously clear all stage words, reg_wr_en bits, counter, md_busy and id_stall to 0, with FSM=IDLE.
REQ-030 Reset asserted during BUSY SHALL abandon the operation with no residual stall after release.
REQ-031 The first edge after rst_n rises SHALL sample ID normally.

Verification
REQ-032 SHALL cover: LD then ST back-to-back -> ex_ctrl rwc=2 with mem_rd=1, then mem_wr=1; wb_ctrl shows LD at cycle 3.
REQ-033 SHALL cover: DIV with DIV_CYCLES=32 -> id_stall high for 31 cycles, 31 bubbles on mem_ctrl, DIV reaches mem_ctrl at cycle 33.
REQ-034 SHALL cover: MUL with MUL_CYCLES=1 followed by ADD -> no stall; mem_ctrl shows rwc=3 then rwc=0 on consecutive cycles.
REQ-035 SHALL cover: flush_ex together with stall_in during BUSY at count 10 -> md_busy=0 next cycle, ex_ctrl=0, MEM unchanged.
REQ-036 SHALL cover: ENABLE_M=0 with funct7=0000001, and opcode 1111111 -> ex_ctrl illegal=1 with all other bits 0 and reg_wr_en=0.
REQ-037 SHALL cover: rst_n low mid-DIV at count 5 -> all outputs 0 immediately; after release, ADD flows with no stall.
